sd_card_cmd_responder: RTL and testbench

Card-side endpoint of the SD CMD line, used as the bench and loopback target for the micro-SD host command path.
- Deserialises 48-bit host command frames sampled on sdCmdIn.
- Checks the CRC7 and end bit, then presents index and argument to a card model.
- Serialises the model-supplied R1, R2 or R3 response back onto the CMD line after the NCR gap.

---
 rtl/sd_card_cmd_responder.sv | 213 +++++++++++++++++++++
 tb/tb_sd_card_cmd_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands,
// checks CRC7/end bit, and returns R1, R2 or R3 after the NCR gap.
//
// Ports:
//   sdClk, sysRstN          clock (rising edge), async active-low reset
//   sdCmdIn                 CMD line sampled from the pad
//   sdCmdOut, sdCmdEn       CMD line drive value and output enable
//   cmdValid                one-cycle pulse per received command frame
//   cmdIndex, cmdArg        index/argument of the last frame (held)
//   cmdCrcOk                CRC7 and end bit good (held)
//   respValid/Type/Data     response from the card model (WAIT_RESP only)
//   busy                    frame in flight or response pending/driving
module sd_card_cmd_responder #(
    parameter int NCR       = 2,
    parameter int RESP_WAIT = 64
) (
    input  logic         sdClk,
    input  logic         sysRstN,
    input  logic         sdCmdIn,
    output logic         sdCmdOut,
    output logic         sdCmdEn,
    output logic         cmdValid,
    output logic [5:0]   cmdIndex,
    output logic [31:0]  cmdArg,
    output logic         cmdCrcOk,
    input  logic         respValid,
    input  logic [1:0]   respType,
    input  logic [119:0] respData,
    output logic         busy
);

    // The wait counter also times the NCR gap, so it must reach
    // whichever of the two limits is larger, plus the overrun value.
    localparam int WAIT_MAX = (RESP_WAIT > NCR) ? RESP_WAIT : NCR;
    localparam int WW       = $clog2(WAIT_MAX + 2);
    localparam logic [WW-1:0] WAIT_LIM = WW'(RESP_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        RX_HDR,
        RX,
        DISCARD,
        WAIT_RESP,
        GAP,
        TX
    } state_t;

    state_t         state;
    logic [7:0]     bitCnt;
    logic [45:0]    rxShift;
    logic [6:0]     crc;
    logic [WW-1:0]  waitCnt;
    logic [126:0]   txShift;
    logic [1:0]     txType;

    logic           rxOk;
    logic           accept;
    logic           gapMet;
    logic [7:0]     payLen;
    logic           txCrcEn;
    logic [126:0]   loadVal;

    function automatic logic [6:0] crcNext(
        input logic [6:0] c,
        input logic       b
    );
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // rxShift holds frame bits 1..46 when the end bit arrives.
    assign rxOk   = (rxShift[6:0] == crc) && sdCmdIn;
    assign accept = respValid && (waitCnt <= WAIT_LIM);
    assign gapMet = (int'(waitCnt) + 2) >= NCR;

    // Bits after the start bit that carry payload; CRC field follows.
    assign payLen = (txType == 2'b10) ? 8'd128 : 8'd40;
    // R2 CRC skips the 8-bit header, R1 covers the whole header.
    assign txCrcEn = (txType == 2'b01) || (bitCnt >= 8'd8);

    always_comb begin
        loadVal = '0;
        if (respType == 2'b10) begin
            loadVal = {1'b0, 6'h3F, respData};
        end else if (respType == 2'b01) begin
            loadVal = {1'b0, cmdIndex, respData[31:0], 88'd0};
        end else begin
            loadVal = {1'b0, 6'h3F, respData[31:0], 88'd0};
        end
    end

    always_ff @(posedge sdClk or negedge sysRstN) begin
        if (!sysRstN) begin
            state    <= IDLE;
            sdCmdOut <= 1'b1;
            sdCmdEn  <= 1'b0;
            cmdValid <= 1'b0;
            cmdIndex <= '0;
            cmdArg   <= '0;
            cmdCrcOk <= 1'b0;
            busy     <= 1'b0;
            bitCnt   <= '0;
            rxShift  <= '0;
            crc      <= '0;
            waitCnt  <= '0;
            txShift  <= '0;
            txType   <= 2'b00;
        end else begin
            cmdValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!sdCmdIn) begin
                        state  <= RX_HDR;
                        busy   <= 1'b1;
                        crc    <= '0;
                        bitCnt <= '0;
                    end
                end
                RX_HDR: begin
                    bitCnt  <= '0;
                    rxShift <= {rxShift[44:0], sdCmdIn};
                    crc     <= crcNext(crc, sdCmdIn);
                    state   <= sdCmdIn ? RX : DISCARD;
                end
                DISCARD: begin
                    bitCnt <= bitCnt + 8'd1;
                    if (bitCnt == 8'd45) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RX: begin
                    bitCnt  <= bitCnt + 8'd1;
                    rxShift <= {rxShift[44:0], sdCmdIn};
                    if (bitCnt < 8'd38) begin
                        crc <= crcNext(crc, sdCmdIn);
                    end
                    if (bitCnt == 8'd45) begin
                        cmdValid <= 1'b1;
                        cmdIndex <= rxShift[44:39];
                        cmdArg   <= rxShift[38:7];
                        cmdCrcOk <= rxOk;
                        waitCnt  <= '0;
                        if (rxOk) begin
                            state <= WAIT_RESP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                WAIT_RESP: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (accept) begin
                        txType  <= respType;
                        txShift <= loadVal;
                        if (respType == 2'b00) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (gapMet) begin
                            state    <= TX;
                            sdCmdEn  <= 1'b1;
                            sdCmdOut <= 1'b0;
                            bitCnt   <= 8'd1;
                            crc      <= '0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (waitCnt > WAIT_LIM) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (gapMet) begin
                        state    <= TX;
                        sdCmdEn  <= 1'b1;
                        sdCmdOut <= 1'b0;
                        bitCnt   <= 8'd1;
                        crc      <= '0;
                    end
                end
                TX: begin
                    bitCnt <= bitCnt + 8'd1;
                    if (bitCnt < payLen) begin
                        sdCmdOut <= txShift[126];
                        txShift  <= {txShift[125:0], 1'b0};
                        if (txCrcEn) begin
                            crc <= crcNext(crc, txShift[126]);
                        end
                    end else if (bitCnt < payLen + 8'd7) begin
                        // R3 carries an all-ones CRC field
                        sdCmdOut <= (txType == 2'b11) ? 1'b1 : crc[6];
                        crc      <= {crc[5:0], 1'b0};
                    end else if (bitCnt == payLen + 8'd7) begin
                        sdCmdOut <= 1'b1;
                    end else begin
                        sdCmdOut <= 1'b1;
                        sdCmdEn  <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Scoreboard bench for sd_card_cmd_responder: directed command
// frames, queued expectations, monitors on cmdValid and sdCmdEn.
module tb_sd_card_cmd_responder;

    localparam int NCR       = 2;
    localparam int RESP_WAIT = 64;

    logic         sdClk = 1'b0;
    logic         sysRstN = 1'b0;
    logic         sdCmdIn = 1'b1;
    logic         sdCmdOut;
    logic         sdCmdEn;
    logic         cmdValid;
    logic [5:0]   cmdIndex;
    logic [31:0]  cmdArg;
    logic         cmdCrcOk;
    logic         respValid = 1'b0;
    logic [1:0]   respType = 2'b00;
    logic [119:0] respData = '0;
    logic         busy;

    sd_card_cmd_responder #(
        .NCR       (NCR),
        .RESP_WAIT (RESP_WAIT)
    ) dut (
        .sdClk     (sdClk),
        .sysRstN   (sysRstN),
        .sdCmdIn   (sdCmdIn),
        .sdCmdOut  (sdCmdOut),
        .sdCmdEn   (sdCmdEn),
        .cmdValid  (cmdValid),
        .cmdIndex  (cmdIndex),
        .cmdArg    (cmdArg),
        .cmdCrcOk  (cmdCrcOk),
        .respValid (respValid),
        .respType  (respType),
        .respData  (respData),
        .busy      (busy)
    );

    always #5 sdClk = ~sdClk;

    int cyc = 0;
    always @(posedge sdClk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        ok;
    } cmd_exp_t;

    typedef struct {
        logic [135:0] bits;
        int           len;
        int           delta;
    } rsp_exp_t;

    cmd_exp_t cmdQ[$];
    rsp_exp_t rspQ[$];
    bit       abortTx = 1'b0;
    int       cvCyc = 0;

    task automatic check(
        input string        name,
        input logic [135:0] act,
        input logic [135:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(
        input logic [127:0] d,
        input int           n
    );
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] cmdFrame(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7(128'(h), 40), 1'b1};
    endfunction

    function automatic logic [47:0] r1Frame(
        input logic [5:0]  idx,
        input logic [31:0] st
    );
        logic [39:0] h;
        h = {2'b00, idx, st};
        return {h, crc7(128'(h), 40), 1'b1};
    endfunction

    function automatic logic [135:0] r2Frame(input logic [119:0] cid);
        return {8'h3F, cid, crc7(128'(cid), 120), 1'b1};
    endfunction

    // Command decode monitor
    always @(negedge sdClk) begin
        cmd_exp_t e;
        if (sysRstN && cmdValid) begin
            cvCyc = cyc;
            if (cmdQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmdValid: got unexpected pulse, idx %0h", cmdIndex);
            end else begin
                e = cmdQ.pop_front();
                check("cmdIndex", 136'(cmdIndex), 136'(e.idx));
                check("cmdArg", 136'(cmdArg), 136'(e.arg));
                check("cmdCrcOk", 136'(cmdCrcOk), 136'(e.ok));
            end
        end
    end

    // Response line monitor
    logic         inTx = 1'b0;
    logic [135:0] rxBits = '0;
    int           rxN = 0;
    rsp_exp_t     cur;

    always @(negedge sdClk) begin
        if (!inTx && sdCmdEn) begin
            inTx   = 1'b1;
            rxBits = '0;
            rxN    = 0;
            if (rspQ.size() == 0) begin
                cur.len = 0;
                checks++;
                errors++;
                $display("FAIL response: got unexpected sdCmdEn");
            end else begin
                cur = rspQ.pop_front();
                check("start delay", 136'(cyc - cvCyc), 136'(cur.delta));
            end
        end
        if (inTx) begin
            if (sdCmdEn) begin
                rxBits = {rxBits[134:0], sdCmdOut};
                rxN++;
            end else begin
                inTx = 1'b0;
                if (abortTx) begin
                    abortTx = 1'b0;
                end else if (cur.len != 0) begin
                    check("resp length", 136'(rxN), 136'(cur.len));
                    check("resp bits", rxBits, cur.bits);
                    check("line idle", 136'(sdCmdOut), 136'(1));
                end
            end
        end
    end

    task automatic sendFrame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdClk);
            sdCmdIn = f[i];
        end
        @(negedge sdClk);
        sdCmdIn = 1'b1;
    endtask

    task automatic doCmd(
        input logic [47:0]  f,
        input logic         ok,
        input logic [1:0]   rt,
        input logic [119:0] rd,
        input bit           give,
        input int           d,
        input logic [135:0] eBits,
        input int           eLen
    );
        cmd_exp_t c;
        rsp_exp_t r;
        int       k;
        c.idx = f[45:40];
        c.arg = f[39:8];
        c.ok  = ok;
        cmdQ.push_back(c);
        if (give && ok && rt != 2'b00) begin
            r.bits  = eBits;
            r.len   = eLen;
            r.delta = (d + 1 > NCR - 1) ? d + 1 : NCR - 1;
            rspQ.push_back(r);
        end
        sendFrame(f);
        check("busy at N+1", 136'(busy), 136'(ok));
        if (give) begin
            repeat (d) @(negedge sdClk);
            respValid = 1'b1;
            respType  = rt;
            respData  = rd;
            @(negedge sdClk);
            respValid = 1'b0;
        end
        k = 0;
        while (k < 400 && (busy || sdCmdEn)) begin
            @(negedge sdClk);
            k++;
        end
        check("idle after cmd", 136'({busy, sdCmdEn}), 136'(0));
        repeat (3) @(negedge sdClk);
    endtask

    localparam logic [119:0] CID = 120'h035344_5344313647_80_12345678_0138;

    initial begin
        rsp_exp_t r;
        cmd_exp_t c;

        @(negedge sdClk);
        check("reset outputs",
              136'({sdCmdOut, sdCmdEn, cmdValid, cmdIndex,
                    cmdArg, cmdCrcOk, busy}),
              136'({1'b1, 42'd0}));
        sysRstN = 1'b1;
        repeat (2) @(negedge sdClk);

        // respValid in IDLE must be ignored
        respValid = 1'b1;
        respType  = 2'b01;
        repeat (2) @(negedge sdClk);
        respValid = 1'b0;
        repeat (4) @(negedge sdClk);
        check("idle respValid", 136'({sdCmdEn, busy}), 136'(0));

        // CMD0, no response
        doCmd(48'h400000000095, 1'b1, 2'b00, '0, 1'b1, 0, '0, 0);

        // CMD8 with R1
        doCmd(48'h48000001AA87, 1'b1, 2'b01, 120'h1AA, 1'b1, 0,
              136'(48'h08000001AA13), 48);

        // CMD0 with bad CRC
        doCmd(48'h400000000097, 1'b0, 2'b01, 120'h1AA, 1'b1, 0, '0, 0);

        // CMD55 with delayed R1, then ACMD41 with R3
        doCmd(48'h770000000065, 1'b1, 2'b01, 120'h120, 1'b1, 3,
              136'(r1Frame(6'd55, 32'h120)), 48);
        doCmd(cmdFrame(6'd41, 32'h40FF8000), 1'b1, 2'b11,
              120'h80FF8000, 1'b1, 0, 136'(48'h3F80FF8000FF), 48);

        // CMD2 with R2
        doCmd(48'h42000000004D, 1'b1, 2'b10, CID, 1'b1, 0,
              r2Frame(CID), 136);

        // CMD13 with no model response: abandoned
        doCmd(cmdFrame(6'd13, 32'h00010000), 1'b1, 2'b00, '0,
              1'b0, 0, '0, 0);

        // Reset in the middle of an R2 response
        c.idx = 6'd2;
        c.arg = 32'd0;
        c.ok  = 1'b1;
        cmdQ.push_back(c);
        r.bits  = r2Frame(CID);
        r.len   = 136;
        r.delta = NCR - 1;
        rspQ.push_back(r);
        sendFrame(48'h42000000004D);
        respValid = 1'b1;
        respType  = 2'b10;
        respData  = CID;
        @(negedge sdClk);
        respValid = 1'b0;
        repeat (60) @(negedge sdClk);
        check("en mid R2", 136'(sdCmdEn), 136'(1));
        abortTx = 1'b1;
        #2;
        sysRstN = 1'b0;
        #1;
        check("async release",
              136'({sdCmdEn, sdCmdOut, busy, cmdIndex}),
              136'({1'b0, 1'b1, 1'b0, 6'd0}));
        repeat (2) @(negedge sdClk);
        sysRstN = 1'b1;
        repeat (2) @(negedge sdClk);

        doCmd(48'h400000000095, 1'b1, 2'b00, '0, 1'b1, 0, '0, 0);

        check("cmd queue empty", 136'(cmdQ.size()), 136'(0));
        check("resp queue empty", 136'(rspQ.size()), 136'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
